// File: rtl/uart_tx_if.sv
// UART transmitter host-side request bundle.
// The host drives requests and the transmitter reports busy/done.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_start, din,
    input  tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din,
    output tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start, DBIT data LSB-first, optional parity, stop.
// Bit timing comes from a 16x oversampling tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     s_tick,
  uart_tx_if.slave host,
  output logic     tx
);
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            p, p_n;
  logic            tx_n;
  logic            busy;
  logic            done;
  logic            bit_end;

  assign bit_end = s_tick && (s == SW'(15));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      p     <= 1'b0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      p     <= p_n;
      tx    <= tx_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    p_n     = p;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (host.tx_start) begin
          b_n     = host.din;
          s_n     = '0;
          p_n     = (PARITY == 2);
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          s_n     = '0;
          n_n     = '0;
          state_n = DATA;
        end else if (s_tick) begin
          s_n = s + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          s_n = '0;
          b_n = b >> 1;
          p_n = p ^ b[0];
          if (n == NW'(DBIT - 1))
            state_n = (PARITY != 0) ? PAR : STOP;
          else
            n_n = n + 1'b1;
        end else if (s_tick) begin
          s_n = s + 1'b1;
        end
      end
      PAR: begin
        if (bit_end) begin
          s_n     = '0;
          state_n = STOP;
        end else if (s_tick) begin
          s_n = s + 1'b1;
        end
      end
      STOP: begin
        if (s_tick && (s == SW'(SB_TICK - 1))) begin
          s_n     = '0;
          done    = 1'b1;
          state_n = IDLE;
        end else if (s_tick) begin
          s_n = s + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so it lines up with state
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
      PAR:     tx_n = p_n;
      default: tx_n = 1'b1;
    endcase
  end

  assign host.tx_busy      = busy;
  assign host.tx_done_tick = done;
endmodule
